toggle_bank: RTL and testbench

Parametrised multi-bit toggle register: the multi-channel successor to the single-bit toggle flop. It holds WIDTH independent toggle bits with per-bit toggle enables, selectable level or rising-edge toggle mode, parallel load, hold and clear. It reports which bits changed each cycle and keeps a saturating count of change events. It sits in the register/control layer for LED patterns, clock-divider taps and software-visible flag banks.

---
 rtl/toggle_pkg.sv | 16 +
 rtl/toggle_cell.sv | 77 +++++++
 rtl/toggle_bank.sv | 81 ++++++++
 tb/tb_toggle_bank.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/toggle_pkg.sv
// -----------------------------------------------------------------------------
// toggle_pkg
// Shared definitions for the toggle_bank register block.
//   MODE_LEVEL : q toggles wherever t is high
//   MODE_EDGE  : q toggles on a 0->1 transition of t
//   MODE_HOLD  : q keeps its value
//   MODE_CLEAR : q returns to its reset value
// -----------------------------------------------------------------------------
package toggle_pkg;

    localparam logic [1:0] MODE_LEVEL = 2'b00;
    localparam logic [1:0] MODE_EDGE  = 2'b01;
    localparam logic [1:0] MODE_HOLD  = 2'b10;
    localparam logic [1:0] MODE_CLEAR = 2'b11;

endpackage : toggle_pkg

// File: rtl/toggle_cell.sv
// -----------------------------------------------------------------------------
// toggle_cell
// One-bit slice of toggle_bank: state bit, previous-t capture for edge
// detection, next-state selection and a registered change flag.
//
// Ports
//   i_clk      rising-edge clock
//   i_reset    synchronous active-high reset
//   i_mode     operating mode (toggle_pkg encodings)
//   i_t        toggle request for this bit
//   i_load     parallel load strobe (overrides mode)
//   i_d        parallel load data for this bit
//   o_q        registered state bit
//   o_toggled  registered flag: high in the cycle the new o_q differs
//   o_change   combinational "this bit changes on the next edge"
// -----------------------------------------------------------------------------
module toggle_cell
    import toggle_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] i_mode,
    input  logic       i_t,
    input  logic       i_load,
    input  logic       i_d,
    output logic       o_q,
    output logic       o_toggled,
    output logic       o_change
);

    logic r_q;
    logic r_t_prev;
    logic r_toggled;
    logic w_q_next;

    // NOTE: every always_comb output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        w_q_next = r_q;
        if (i_load) begin
            w_q_next = i_d;
        end else begin
            case (i_mode)
                MODE_LEVEL: w_q_next = r_q ^ i_t;
                MODE_EDGE:  w_q_next = r_q ^ (i_t & ~r_t_prev);
                MODE_HOLD:  w_q_next = r_q;
                MODE_CLEAR: w_q_next = RESET_VAL;
                default:    w_q_next = r_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // sample their inputs from the same pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_q       <= RESET_VAL;
            r_toggled <= 1'b0;
            // t keeps being tracked during reset, so a t held high across
            // reset release is not seen as a fresh edge.
            r_t_prev  <= i_t;
        end else begin
            r_q       <= w_q_next;
            r_toggled <= w_q_next ^ r_q;
            // Tracked regardless of mode/load: an edge arriving during
            // HOLD, CLEAR or load is consumed and never replayed.
            r_t_prev  <= i_t;
        end
    end

    assign o_q       = r_q;
    assign o_toggled = r_toggled;
    assign o_change  = w_q_next ^ r_q;

endmodule : toggle_cell

// File: rtl/toggle_bank.sv
// -----------------------------------------------------------------------------
// toggle_bank
// WIDTH independent toggle bits with per-bit enables, level/edge toggle modes,
// parallel load, hold and clear, plus a saturating count of cycles in which
// any bit changed.
//
// Parameters
//   WIDTH      number of toggle bits (1..32)
//   CNT_W      width of the change-event counter
//   RESET_VAL  value of q after reset and in CLEAR mode
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   mode          00 LEVEL, 01 EDGE, 10 HOLD, 11 CLEAR
//   t             per-bit toggle request
//   load          parallel load strobe (priority over mode)
//   d             parallel load data
//   count_clr     synchronous clear of toggle_count
//   q             register state
//   toggled       registered per-bit change flags
//   toggle_count  saturating count of change-event cycles
// -----------------------------------------------------------------------------
module toggle_bank
    import toggle_pkg::*;
#(
    parameter int                 WIDTH     = 8,
    parameter int                 CNT_W     = 16,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             count_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] toggled,
    output logic [CNT_W-1:0] toggle_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] w_change;
    logic             w_event;
    logic [CNT_W-1:0] r_count;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        toggle_cell #(
            .RESET_VAL (RESET_VAL[i])
        ) u_cell (
            .i_clk     (clk),
            .i_reset   (reset),
            .i_mode    (mode),
            .i_t       (t[i]),
            .i_load    (load),
            .i_d       (d[i]),
            .o_q       (q[i]),
            .o_toggled (toggled[i]),
            .o_change  (w_change[i])
        );
    end

    assign w_event = |w_change;

    // Priority: reset, then count_clr (beats a same-cycle event), then a
    // saturating increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (count_clr) begin
            r_count <= '0;
        end else if (w_event && (r_count != CNT_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign toggle_count = r_count;

endmodule : toggle_bank

// File: tb/tb_toggle_bank.sv
module tb_toggle_bank;
    import toggle_pkg::*;

    localparam logic [7:0] RST_V = 8'hA5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode = MODE_LEVEL;
    logic [7:0] t = 8'h00;
    logic       load = 1'b0;
    logic [7:0] d = 8'h00;
    logic       count_clr = 1'b0;

    logic [7:0]  q, toggled, q_s, toggled_s;
    logic [15:0] toggle_count;
    logic [1:0]  toggle_count_s;

    always #5 clk = ~clk;

    toggle_bank #(.WIDTH(8), .CNT_W(16), .RESET_VAL(RST_V)) dut (
        .clk(clk), .reset(reset), .mode(mode), .t(t), .load(load), .d(d),
        .count_clr(count_clr), .q(q), .toggled(toggled), .toggle_count(toggle_count)
    );

    // Narrow-counter instance on the same stimulus, for saturation.
    toggle_bank #(.WIDTH(8), .CNT_W(2), .RESET_VAL(RST_V)) dut_sat (
        .clk(clk), .reset(reset), .mode(mode), .t(t), .load(load), .d(d),
        .count_clr(count_clr), .q(q_s), .toggled(toggled_s), .toggle_count(toggle_count_s)
    );

    typedef struct packed {
        logic [7:0]  q;
        logic [7:0]  tog;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [7:0]  m_q = RST_V;
    logic [7:0]  m_tp = 8'h00;
    logic [15:0] m_cnt = 16'd0;
    logic [1:0]  m_cnt2 = 2'd0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, push the model's prediction, then pop and
    // compare once the DUT has taken the edge.
    task automatic step(input logic rst, input logic [1:0] md, input logic [7:0] tv,
                        input logic ld, input logic [7:0] dv, input logic cclr);
        exp_t e;
        logic [7:0] nq;
        @(negedge clk);
        reset = rst; mode = md; t = tv; load = ld; d = dv; count_clr = cclr;
        if (rst) begin
            e.q = RST_V; e.tog = 8'h00; e.cnt = 16'd0; e.cnt2 = 2'd0;
        end else begin
            if (ld)                      nq = dv;
            else if (md == MODE_LEVEL)   nq = m_q ^ tv;
            else if (md == MODE_EDGE)    nq = m_q ^ (tv & ~m_tp);
            else if (md == MODE_CLEAR)   nq = RST_V;
            else                         nq = m_q;
            e.q   = nq;
            e.tog = nq ^ m_q;
            if (cclr) begin
                e.cnt = 16'd0; e.cnt2 = 2'd0;
            end else begin
                e.cnt  = (e.tog != 8'h00 && m_cnt  != 16'hFFFF) ? m_cnt + 16'd1 : m_cnt;
                e.cnt2 = (e.tog != 8'h00 && m_cnt2 != 2'd3)     ? m_cnt2 + 2'd1 : m_cnt2;
            end
        end
        m_q = e.q; m_tp = tv; m_cnt = e.cnt; m_cnt2 = e.cnt2;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("q",        32'(q),              32'(e.q));
            check("toggled",  32'(toggled),        32'(e.tog));
            check("count",    32'(toggle_count),   32'(e.cnt));
            check("q_sat",    32'(q_s),            32'(e.q));
            check("count_sat",32'(toggle_count_s), 32'(e.cnt2));
        end
    endtask

    initial begin
        // Reset and LEVEL
        step(1'b1, MODE_LEVEL, 8'h0F, 1'b0, 8'h00, 1'b0);
        step(1'b1, MODE_LEVEL, 8'h0F, 1'b0, 8'h00, 1'b0);
        check("rst_q", 32'(q), 32'h A5);
        step(1'b0, MODE_LEVEL, 8'h0F, 1'b0, 8'h00, 1'b0);
        check("lvl_q1", 32'(q), 32'hAA);
        step(1'b0, MODE_LEVEL, 8'h0F, 1'b0, 8'h00, 1'b0);
        check("lvl_q2", 32'(q), 32'hA5);
        step(1'b0, MODE_LEVEL, 8'h0F, 1'b0, 8'h00, 1'b0);
        check("lvl_q3", 32'(q), 32'hAA);
        check("lvl_tog", 32'(toggled), 32'h0F);
        check("lvl_cnt", 32'(toggle_count), 32'd3);

        // EDGE: pulse on bit0 held for 4 cycles gives one toggle
        step(1'b0, MODE_EDGE, 8'h00, 1'b0, 8'h00, 1'b0);
        step(1'b0, MODE_EDGE, 8'h01, 1'b0, 8'h00, 1'b0);
        check("edge_q", 32'(q), 32'hAB);
        check("edge_tog", 32'(toggled), 32'h01);
        for (int i = 0; i < 3; i++) step(1'b0, MODE_EDGE, 8'h01, 1'b0, 8'h00, 1'b0);
        check("edge_hold_tog", 32'(toggled), 32'h00);
        check("edge_cnt", 32'(toggle_count), 32'd4);

        // Priority: load beats CLEAR and toggles; reload of same data is silent
        step(1'b0, MODE_CLEAR, 8'hFF, 1'b1, 8'h3C, 1'b0);
        check("ld_q", 32'(q), 32'h3C);
        step(1'b0, MODE_CLEAR, 8'hFF, 1'b1, 8'h3C, 1'b0);
        check("ld_same_tog", 32'(toggled), 32'h00);
        check("ld_same_cnt", 32'(toggle_count), 32'd5);

        // Edge consumed during HOLD is not replayed in EDGE
        step(1'b0, MODE_HOLD, 8'h00, 1'b0, 8'h00, 1'b0);
        step(1'b0, MODE_HOLD, 8'hFF, 1'b0, 8'h00, 1'b0);
        step(1'b0, MODE_EDGE, 8'hFF, 1'b0, 8'h00, 1'b0);
        check("hold_q", 32'(q), 32'h3C);
        check("hold_cnt", 32'(toggle_count), 32'd5);

        // CLEAR mode returns to reset value
        step(1'b0, MODE_CLEAR, 8'h00, 1'b0, 8'h00, 1'b0);
        check("clr_q", 32'(q), 32'hA5);

        // Saturation on 2-bit counter, then count_clr vs event
        step(1'b0, MODE_LEVEL, 8'h00, 1'b0, 8'h00, 1'b1);
        check("cclr_cnt", 32'(toggle_count_s), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, MODE_LEVEL, 8'h01, 1'b0, 8'h00, 1'b0);
            check("sat_seq", 32'(toggle_count_s), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        step(1'b0, MODE_LEVEL, 8'h01, 1'b0, 8'h00, 1'b1);
        check("cclr_evt", 32'(toggle_count_s), 32'd0);
        check("cclr_evt_tog", 32'(toggled), 32'h01);
        step(1'b0, MODE_LEVEL, 8'h01, 1'b0, 8'h00, 1'b0);
        check("after_cclr", 32'(toggle_count_s), 32'd1);

        // Reset mid-operation with t held high in EDGE mode
        step(1'b0, MODE_EDGE, 8'hFF, 1'b0, 8'h00, 1'b0);
        step(1'b1, MODE_EDGE, 8'hFF, 1'b0, 8'h00, 1'b0);
        step(1'b1, MODE_EDGE, 8'hFF, 1'b0, 8'h00, 1'b0);
        check("mid_rst_q", 32'(q), 32'hA5);
        check("mid_rst_cnt", 32'(toggle_count), 32'd0);
        step(1'b0, MODE_EDGE, 8'hFF, 1'b0, 8'h00, 1'b0);
        step(1'b0, MODE_EDGE, 8'hFF, 1'b0, 8'h00, 1'b0);
        check("post_rst_q", 32'(q), 32'hA5);
        check("post_rst_tog", 32'(toggled), 32'h00);
        step(1'b0, MODE_EDGE, 8'h00, 1'b0, 8'h00, 1'b0);
        step(1'b0, MODE_EDGE, 8'hFF, 1'b0, 8'h00, 1'b0);
        check("re_edge_q", 32'(q), 32'h5A);
        check("re_edge_tog", 32'(toggled), 32'hFF);
        step(1'b0, MODE_HOLD, 8'hFF, 1'b0, 8'h00, 1'b0);
        check("pulse_end", 32'(toggled), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_toggle_bank
